// File: rtl/daq_readout_sched.sv
// Readout scheduler: queues accepted L1As, waits out each event's memory write window,
// then hands events one at a time to the readout engine. Optional watchdog: DAQ_SCHED_TIMEOUT_EN.
module daq_readout_sched #(
    parameter int QA_W    = 3,
    parameter int CNT_W   = 12,
    parameter int THR_LVL = 6
) (
    input  logic             clk,
    input  logic             hard_rst,
    input  logic             l1a_acc,
    input  logic             lct_seen,
    input  logic [3:0]       l1a_window,
    input  logic [4:0]       fifo_tbins,
    input  logic [1:0]       fifo_mode,
    input  logic             send_empty,
    output logic             rd_start,
    input  logic             rd_ack,
    input  logic             rd_done,
    output logic [CNT_W-1:0] rd_l1a_num,
    output logic [3:0]       rd_lct_bins,
    output logic [4:0]       rd_raw_bins,
    output logic             throttle,
    output logic [QA_W:0]    occupancy,
    output logic [7:0]       ovf_cnt
`ifdef DAQ_SCHED_TIMEOUT_EN
    ,
    output logic             sched_timeout,
    output logic [7:0]       timeout_cnt
`endif
);

    localparam int              DEPTH    = 2**QA_W;
    localparam logic [QA_W:0]   FULL_LVL = DEPTH[QA_W:0];
    localparam logic [QA_W:0]   THR      = THR_LVL[QA_W:0];
    localparam logic [QA_W:0]   OCC_ONE  = 1;
    localparam logic [QA_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] NUM_ONE = 1;

    typedef enum logic [1:0] {IDLE, WAIT, PRESENT, BUSY} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] num;
        logic [3:0]       lct;
        logic [4:0]       raw;
        logic [5:0]       dly;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           mem [DEPTH];
    entry_t           new_entry;
    logic [QA_W-1:0]  wr_ptr, rd_ptr;
    logic [QA_W:0]    occ_nxt;
    logic [CNT_W-1:0] l1a_num;
    logic [5:0]       head_cnt;
    logic [4:0]       max_bins;
    logic             full, push, pop, drop;
    logic             timeout_hit;

    // Entry captured from this cycle's configuration; the delay covers the longer write window.
    always_comb begin
        max_bins      = ({1'b0, l1a_window} > fifo_tbins) ? {1'b0, l1a_window} : fifo_tbins;
        new_entry.num = l1a_num;
        new_entry.lct = (lct_seen || send_empty) ? l1a_window : 4'd0;
        new_entry.raw = (fifo_mode != 2'd0) ? fifo_tbins : 5'd0;
        new_entry.dly = {1'b0, max_bins} + 6'd2;
    end

    assign full = (occupancy == FULL_LVL);
    assign pop  = (state == PRESENT) && rd_ack;
    assign push = l1a_acc && (!full || pop);
    assign drop = l1a_acc && full && !pop;

    always_comb begin
        // NOTE: default assignment first so every path drives occ_nxt and no latch is inferred.
        occ_nxt = occupancy;
        case ({push, pop})
            2'b10:   occ_nxt = occupancy + OCC_ONE;
            2'b01:   occ_nxt = occupancy - OCC_ONE;
            default: occ_nxt = occupancy;
        endcase
    end

    // NOTE: queue storage is not reset; pointers and occupancy alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            throttle  <= 1'b0;
            l1a_num   <= '0;
            ovf_cnt   <= '0;
            head_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            occupancy <= occ_nxt;
            throttle  <= (occ_nxt >= THR);
            if (l1a_acc) l1a_num <= l1a_num + NUM_ONE;
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            // Only the head counts down; a new head loads its own delay when it arrives.
            if (pop)
                head_cnt <= (occupancy > OCC_ONE) ? mem[rd_ptr + PTR_ONE].dly : new_entry.dly;
            else if (push && occupancy == '0)
                head_cnt <= new_entry.dly;
            else if (occupancy != '0 && head_cnt != '0)
                head_cnt <= head_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            rd_l1a_num  <= '0;
            rd_lct_bins <= '0;
            rd_raw_bins <= '0;
        end else if (state == WAIT && head_cnt == '0) begin
            rd_l1a_num  <= mem[rd_ptr].num;
            rd_lct_bins <= mem[rd_ptr].lct;
            rd_raw_bins <= mem[rd_ptr].raw;
        end
    end

`ifdef DAQ_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign timeout_hit = (state == BUSY) && !rd_done && (wd_cnt == 16'hFFFF);

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            wd_cnt      <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state != BUSY)          wd_cnt <= '0;
            else if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
            if (timeout_hit && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (occupancy != '0) state_nxt = WAIT;
            WAIT:    if (head_cnt == '0)  state_nxt = PRESENT;
            PRESENT: if (rd_ack)          state_nxt = BUSY;
            BUSY:    if (rd_done || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_start = (state == PRESENT);
`ifdef DAQ_SCHED_TIMEOUT_EN
        sched_timeout = timeout_hit;
`endif
    end

endmodule

// File: tb/tb_daq_readout_sched.sv
// Scoreboard bench for daq_readout_sched: stimulus pushes expected events, a monitor
// checks each presented event in order. Define DAQ_SCHED_TIMEOUT_EN to add the watchdog test.
module tb_daq_readout_sched;

    logic        clk = 1'b0;
    logic        hard_rst = 1'b1;
    logic        l1a_acc = 1'b0, lct_seen = 1'b0, send_empty = 1'b0;
    logic [3:0]  l1a_window = '0;
    logic [4:0]  fifo_tbins = '0;
    logic [1:0]  fifo_mode = '0;
    logic        rd_start, rd_ack = 1'b0, rd_done = 1'b0;
    logic [11:0] rd_l1a_num;
    logic [3:0]  rd_lct_bins;
    logic [4:0]  rd_raw_bins;
    logic        throttle;
    logic [3:0]  occupancy;
    logic [7:0]  ovf_cnt;
`ifdef DAQ_SCHED_TIMEOUT_EN
    logic        sched_timeout;
    logic [7:0]  timeout_cnt;
`endif

    daq_readout_sched dut (
        .clk(clk), .hard_rst(hard_rst), .l1a_acc(l1a_acc), .lct_seen(lct_seen),
        .l1a_window(l1a_window), .fifo_tbins(fifo_tbins), .fifo_mode(fifo_mode),
        .send_empty(send_empty), .rd_start(rd_start), .rd_ack(rd_ack), .rd_done(rd_done),
        .rd_l1a_num(rd_l1a_num), .rd_lct_bins(rd_lct_bins), .rd_raw_bins(rd_raw_bins),
        .throttle(throttle), .occupancy(occupancy), .ovf_cnt(ovf_cnt)
`ifdef DAQ_SCHED_TIMEOUT_EN
        , .sched_timeout(sched_timeout), .timeout_cnt(timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int num; int lct; int raw;} exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int num, input int lct, input int raw);
        exp_t e;
        e.num = num; e.lct = lct; e.raw = raw;
        sb.push_back(e);
    endtask

    // Drive one event's configuration and the L1A pulse; entered and left at a falling edge.
    task automatic drive_ev(input bit lct, input bit se, input int win, input int tb, input int mode);
        lct_seen   = lct;
        send_empty = se;
        l1a_window = 4'(win);
        fifo_tbins = 5'(tb);
        fifo_mode  = 2'(mode);
        l1a_acc    = 1'b1;
    endtask

    task automatic enq(input bit lct, input bit se, input int win, input int tb, input int mode);
        drive_ev(lct, se, win, tb, mode);
        @(negedge clk);
        l1a_acc = 1'b0;
    endtask

    task automatic wait_start();
        int cyc = 0;
        while (!rd_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!rd_start) check("rd_start_wait_timeout", rd_start, 1);
    endtask

    task automatic serve();
        wait_start();
        if (rd_start) begin
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
            check("rd_start_after_ack", rd_start, 0);
            rd_done = 1'b1;
            @(negedge clk);
            rd_done = 1'b0;
        end
    endtask

    // Monitor: every rising rd_start consumes the oldest expected event.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_start && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_event_num", rd_l1a_num, -1);
                end else begin
                    e = sb.pop_front();
                    check("rd_l1a_num", rd_l1a_num, e.num);
                    check("rd_lct_bins", rd_lct_bins, e.lct);
                    check("rd_raw_bins", rd_raw_bins, e.raw);
                end
            end
            prev = rd_start;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        int occ_tbl[10];
        int thr_tbl[10];
        occ_tbl = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
        thr_tbl = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        hard_rst = 1'b0;
        @(negedge clk);
        check("reset_rd_start", rd_start, 0);
        check("reset_occupancy", occupancy, 0);
        check("reset_throttle", throttle, 0);
        check("reset_ovf_cnt", ovf_cnt, 0);
        check("reset_rd_l1a_num", rd_l1a_num, 0);

        // Single event: ready_dly = max(4,7)+2 = 9, rd_start at cycle 10
        push_exp(0, 4, 7);
        drive_ev(1, 0, 4, 7, 1);
        @(negedge clk);
        l1a_acc = 1'b0;
        check("single_occupancy", occupancy, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rd_start) begin
                lat = i;
                break;
            end
        end
        check("single_latency", lat, 10);
        serve();
        check("single_occupancy_after", occupancy, 0);

        // Empty / no-raw handling
        push_exp(1, 0, 3);
        enq(0, 0, 5, 3, 2);
        serve();
        push_exp(2, 5, 0);
        enq(0, 1, 5, 3, 0);
        serve();
        push_exp(3, 15, 31);
        enq(1, 0, 15, 31, 3);
        serve();

        // Burst of 10 with the engine stalled; numbering restarts after reset
        hard_rst = 1'b1;
        @(negedge clk);
        hard_rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            drive_ev(1, 0, 2, 2, 1);
            if (k < 8) push_exp(k, 2, 2);
            @(negedge clk);
            check($sformatf("burst_occupancy_%0d", k), occupancy, occ_tbl[k]);
            check($sformatf("burst_throttle_%0d", k), throttle, thr_tbl[k]);
        end
        l1a_acc = 1'b0;
        check("burst_ovf_cnt", ovf_cnt, 2);

        // Full queue: pop and enqueue in the same cycle
        wait_start();
        push_exp(10, 9, 0);
        drive_ev(0, 1, 9, 0, 1);
        rd_ack = 1'b1;
        @(negedge clk);
        l1a_acc = 1'b0;
        rd_ack  = 1'b0;
        check("full_swap_occupancy", occupancy, 8);
        check("full_swap_ovf_cnt", ovf_cnt, 2);
        check("full_swap_rd_start", rd_start, 0);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        repeat (8) serve();
        check("drain_occupancy", occupancy, 0);
        check("drain_throttle", throttle, 0);

        // Reset while presenting with 3 queued
        push_exp(11, 1, 1);
        enq(1, 0, 1, 1, 1);
        enq(1, 0, 1, 1, 1);
        enq(1, 0, 1, 1, 1);
        wait_start();
        check("pre_reset_occupancy", occupancy, 3);
        #1 hard_rst = 1'b1;
        #1 check("reset_async_rd_start", rd_start, 0);
        sb.delete();
        @(negedge clk);
        hard_rst = 1'b0;
        @(negedge clk);
        check("post_reset_occupancy", occupancy, 0);
        push_exp(0, 6, 4);
        enq(1, 1, 6, 4, 1);
        serve();

`ifdef DAQ_SCHED_TIMEOUT_EN
        // Watchdog: rd_done withheld in BUSY
        push_exp(1, 1, 1);
        enq(1, 0, 1, 1, 1);
        wait_start();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        lat = 0;
        while (!sched_timeout && lat < 70000) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_cycles", lat, 65535);
        @(negedge clk);
        check("timeout_cnt", timeout_cnt, 1);
        check("timeout_sched_pulse_cleared", sched_timeout, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
